// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out deframer.
package sipo_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

    localparam int WIDTH_MIN = 2;

endpackage

// File: rtl/sipo_out_slot.sv
// One-entry output holding register with valid/ready handshake and sticky overflow.
module sipo_out_slot
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             word_stb_i,
    input  logic             dout_ready_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             overflow_q;
    logic             slot_free;

    // Handshake: a word transfers on any posedge where dout_valid_o && dout_ready_i;
    // while dout_valid_o is high and dout_ready_i is low, dout_o and dout_valid_o hold.
    assign slot_free = !valid_q || dout_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (word_stb_i) begin
            if (slot_free) begin
                dout_q  <= word_i;
                valid_q <= 1'b1;
            end else begin
                overflow_q <= 1'b1;
            end
        end else if (valid_q && dout_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign overflow_o   = overflow_q;

endmodule

// File: rtl/sipo_deframer.sv
// Rebuilds LSB-first serial bits into WIDTH-bit words aligned by a sync strobe.
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             sin_en,
    input  logic             sin,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overflow,
    output logic             aligned
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > 32) begin : g_bad_width
            $error("sipo_deframer: WIDTH out of range");
        end
    endgenerate

    sipo_state_t      state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    // The shifter's LSB would be shifted out on completion before ever being read, so only
    // the upper WIDTH-1 bits are kept; the full shifter value is {sr_q, unused_bit}.
    logic [WIDTH-2:0] sr_q;
    logic [WIDTH-1:0] word_d;
    logic             word_stb;

    assign word_d   = {sin, sr_q};
    assign word_stb = (state_q == SHIFT) && sin_en && !sync && (bit_cnt_q == LAST_BIT);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            sr_q      <= '0;
        end else if (sin_en && sync) begin
            // Sync realigns in either state; any partial word is discarded.
            state_q          <= SHIFT;
            bit_cnt_q        <= CNT_W'(1);
            sr_q             <= '0;
            sr_q[WIDTH-2]    <= sin;
        end else if (sin_en && state_q == SHIFT) begin
            sr_q <= word_d[WIDTH-1:1];
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end
    end

    assign aligned = (state_q == SHIFT);

    sipo_out_slot #(
        .WIDTH(WIDTH)
    ) u_out_slot (
        .clk_i       (clock),
        .rst_i       (rst),
        .word_i      (word_d),
        .word_stb_i  (word_stb),
        .dout_ready_i(dout_ready),
        .dout_o      (dout),
        .dout_valid_o(dout_valid),
        .overflow_o  (overflow)
    );

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer at WIDTH=4 with hand-computed expected words.
module tb_sipo_deframer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             sin_en;
    logic             sin;
    logic             sync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overflow;
    logic             aligned;

    int errors = 0;
    int checks = 0;

    sipo_deframer #(.WIDTH(WIDTH)) dut (
        .clock     (clk),
        .rst       (rst),
        .sin_en    (sin_en),
        .sin       (sin),
        .sync      (sync),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overflow  (overflow),
        .aligned   (aligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a posedge; outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; sin_en = 1'b0; sin = 1'b0; sync = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sin_en = 1'b1; sin = b; sync = s;
        tick();
        sin_en = 1'b0; sin = 1'b0; sync = 1'b0;
    endtask

    task automatic test_reset();
        dout_ready = 1'b1;
        apply_reset();
        checks++; if (dout !== 4'h0) begin errors++; $display("FAIL rst_dout got %h exp 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", dout_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL rst_aligned got %b exp 0", aligned); end
        // Bits without sync in HUNT are ignored.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL hunt_aligned got %b exp 0", aligned); end
    endtask

    task automatic test_single_word();
        logic [3:0] bits;
        bits = 4'b1011;
        dout_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i], i == 0);
            if (i < 3) begin
                checks++;
                if (dout_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid bit %0d got %b exp 0", i, dout_valid); end
            end
        end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b exp 1", dout_valid); end
        checks++; if (dout !== 4'hB) begin errors++; $display("FAIL t1_dout got %h exp b", dout); end
        checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL t1_aligned got %b exp 1", aligned); end
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_pulse got %b exp 0", dout_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'h6B;
        dout_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            send_bit(bits[i], i == 0);
            if (i == 3 || i == 7) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== (i == 3 ? 4'hB : 4'h6)) begin
                    errors++;
                    $display("FAIL b2b_word bit %0d got v=%b d=%h exp v=1 d=%h", i, dout_valid, dout, (i == 3 ? 4'hB : 4'h6));
                end
            end else if (i > 3) begin
                checks++;
                if (dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap bit %0d got %b exp 0", i, dout_valid); end
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_backpressure();
        logic [11:0] bits;
        bits = 12'h36B;
        dout_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            send_bit(bits[i], i == 0);
            if (i >= 3) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== 4'hB) begin
                    errors++;
                    $display("FAIL bp_hold bit %0d got v=%b d=%h exp v=1 d=b", i, dout_valid, dout);
                end
            end
            if (i == 6 || i == 7) begin
                checks++;
                if (overflow !== (i == 7)) begin errors++; $display("FAIL bp_ovf bit %0d got %b exp %b", i, overflow, (i == 7)); end
            end
        end
        dout_ready = 1'b1;
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %b exp 0", dout_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_same_cycle();
        logic [7:0] bits;
        bits = 8'h6B;
        dout_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) dout_ready = 1'b1;
            send_bit(bits[i], i == 0);
        end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL sc_valid got %b exp 1", dout_valid); end
        checks++; if (dout !== 4'h6) begin errors++; $display("FAIL sc_dout got %h exp 6", dout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sc_ovf got %b exp 0", overflow); end
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL sc_drain got %b exp 0", dout_valid); end
    endtask

    task automatic test_resync();
        dout_ready = 1'b0;
        apply_reset();
        // Partial 2-bit word, then realign and build 4'hA with an idle sync-only cycle.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        send_bit(1'b0, 1'b0);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rs_early got %b exp 0", dout_valid); end
        send_bit(1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b1 || dout !== 4'hA) begin errors++; $display("FAIL rs_word got v=%b d=%h exp v=1 d=a", dout_valid, dout); end
        dout_ready = 1'b1;
        tick();
        // Sync on what would be the last bit discards the partial word.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rs_last_sync got %b exp 0", dout_valid); end
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        checks++; if (dout_valid !== 1'b1 || dout !== 4'h6) begin errors++; $display("FAIL rs_word2 got v=%b d=%h exp v=1 d=6", dout_valid, dout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rs_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_mid_reset();
        logic [3:0] bits;
        bits = 4'b1011;
        dout_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 4; i++) send_bit(bits[i], i == 0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (dout !== 4'h0 || dout_valid !== 1'b0) begin errors++; $display("FAIL mr_out got v=%b d=%h exp v=0 d=0", dout_valid, dout); end
        checks++; if (overflow !== 1'b0 || aligned !== 1'b0) begin errors++; $display("FAIL mr_flags got ovf=%b al=%b exp 0 0", overflow, aligned); end
        for (int i = 0; i < 6; i++) send_bit(1'(i % 2), 1'b0);
        checks++; if (dout_valid !== 1'b0 || aligned !== 1'b0) begin errors++; $display("FAIL mr_nosync got v=%b al=%b exp 0 0", dout_valid, aligned); end
    endtask

    initial begin
        rst = 1'b1; sin_en = 1'b0; sin = 1'b0; sync = 1'b0; dout_ready = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_same_cycle();
        test_resync();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
